// File: rtl/alu_pkg.sv
// Shared types and helpers for the iterative divider.
package alu_pkg;

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} div_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Operand/result handshake bundle for iter_divider.
interface iter_divider_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             dbz;
  logic             ovf;

  modport master (
    output in_valid, is_signed, a, b, out_ready,
    input  in_ready, out_valid, quo, rem, dbz, ovf
  );

  modport slave (
    input  in_valid, is_signed, a, b, out_ready,
    output in_ready, out_valid, quo, rem, dbz, ovf
  );
endinterface

// File: rtl/iter_divider_cond_negate.sv
// Two's-complement negation when neg is set, pass-through otherwise.
module cond_negate #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);
  assign res = neg ? (~val + WIDTH'(1)) : val;
endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: one shift-subtract per cycle on magnitudes,
// with sign fix-up afterwards and single-cycle bypass for b==0 and MIN/-1.
module iter_divider
  import alu_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter bit SIGNED_EN = 1
) (
  input logic           clk,
  input logic           rst,
  iter_divider_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  div_state_e state, state_nx;

  logic [WIDTH-1:0]   a_q, b_q;
  logic               a_neg, b_neg, q_neg, r_neg;
  logic [2*WIDTH-1:0] rq;
  logic [WIDTH-1:0]   dvs;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   quo_q, rem_q;
  logic               dbz_q, ovf_q;

  logic               signed_in, accept, b_zero, ovf_case;
  logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [WIDTH:0]     partial, diff;

  assign signed_in = SIGNED_EN && bus.is_signed;
  assign accept    = bus.in_valid && (state == IDLE);
  assign b_zero    = (bus.b == '0);
  assign ovf_case  = signed_in && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.b);

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (.val(a_q),               .neg(a_neg), .res(mag_a));
  cond_negate #(.WIDTH(WIDTH)) u_neg_b (.val(b_q),               .neg(b_neg), .res(mag_b));
  cond_negate #(.WIDTH(WIDTH)) u_neg_q (.val(rq[WIDTH-1:0]),     .neg(q_neg), .res(quo_fix));
  cond_negate #(.WIDTH(WIDTH)) u_neg_r (.val(rq[2*WIDTH-1:WIDTH]), .neg(r_neg), .res(rem_fix));

  // partial < 2*dvs always holds, so diff[WIDTH] is exactly the borrow.
  assign partial = rq[2*WIDTH-1:WIDTH-1];
  assign diff    = partial - {1'b0, dvs};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (b_zero || ovf_case) ? DONE : PREP;
      PREP: state_nx = DIV;
      DIV:  if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      rq    <= '0;
      dvs   <= '0;
      cnt   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q   <= bus.a;
          b_q   <= bus.b;
          a_neg <= signed_in && bus.a[WIDTH-1];
          b_neg <= signed_in && bus.b[WIDTH-1];
          dbz_q <= b_zero;
          ovf_q <= !b_zero && ovf_case;
          if (b_zero) begin
            quo_q <= '1;
            rem_q <= bus.a;
          end else if (ovf_case) begin
            quo_q <= bus.a;
            rem_q <= '0;
          end
        end
        PREP: begin
          rq    <= {{WIDTH{1'b0}}, mag_a};
          dvs   <= mag_b;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          cnt   <= '0;
        end
        DIV: begin
          rq  <= diff[WIDTH] ? {rq[2*WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          quo_q <= quo_fix;
          rem_q <= rem_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quo       = quo_q;
  assign bus.rem       = rem_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning operand/result width in bits (legal values 8 to 64, even).
REQ-002 The block SHALL have parameter SIGNED_EN, default 1, meaning signed mode is available (0: the is_signed input is ignored and treated as 0).
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  operands valid.
REQ-006 Port: in_ready  output  1  block can accept operands.
REQ-007 Port: is_signed  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-008 Port: a  input  WIDTH  dividend.
REQ-009 Port: b  input  WIDTH  divisor.
REQ-010 Port: out_valid  output  1  result valid.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: quo  output  WIDTH  quotient.
REQ-013 Port: rem  output  WIDTH  remainder.
REQ-014 Port: dbz  output  1  divide-by-zero flag, valid with out_valid.
REQ-015 Port: ovf  output  1  signed overflow flag, valid with out_valid.

Function
REQ-016 The FSM SHALL have states IDLE, PREP, DIV, FIX, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; operands, is_signed, and the sign of each operand SHALL be captured when in_valid and in_ready are both 1.
REQ-018 IDLE->PREP SHALL occur on accept; PREP SHALL convert negative signed operands to magnitudes and record the result signs (quotient negative iff exactly one operand is negative; remainder sign equals dividend sign).
REQ-019 DIV SHALL perform one restoring shift-subtract step per cycle, for exactly WIDTH cycles, counted by a $clog2(WIDTH+1)-bit counter; the datapath is a 2*WIDTH-bit remainder/quotient register.
REQ-020 FIX SHALL apply two's-complement negation to quo and rem per the recorded signs, then move to DONE.
REQ-021 Latency from the accept edge to out_valid=1 SHALL be WIDTH+2 cycles for normal operands.
REQ-022 b==0 SHALL bypass PREP/DIV/FIX: DONE is entered on the cycle after accept with quo=all ones, rem=a, dbz=1, ovf=0.
REQ-023 Signed a=most-negative and b=-1 SHALL bypass likewise: quo=a, rem=0, ovf=1, dbz=0.
REQ-024 In DONE, out_valid=1 and quo/rem/dbz/ovf SHALL stay stable until out_ready=1; on that edge the state SHALL return to IDLE.
REQ-025 A new operand SHALL NOT be accepted in the same cycle the result is consumed (in_ready rises the cycle after the DONE->IDLE edge).
REQ-026 Unsigned results SHALL satisfy a == quo*b + rem with rem < b; signed results SHALL truncate toward zero with |rem| < |b|.
REQ-027 Input changes outside the accept cycle SHALL have no effect on an operation in progress.

Reset
REQ-028 When rst=1 at a rising edge, the state SHALL become IDLE and out_valid, quo, rem, dbz, ovf, and the counter SHALL be 0, aborting any operation in progress, in any state.
REQ-029 in_ready SHALL be 1 on the first cycle after rst is deasserted.

Structure
REQ-030 The state enum and the DIV counter-width function SHALL reside in shared package alu_pkg.
REQ-031 Conditional two's-complement negation SHALL be a sub-module cond_negate (parameter WIDTH), instantiated for the operands in PREP and the results in FIX.
REQ-032 The design SHALL contain no combinational loop over WIDTH stages; one subtractor of WIDTH+1 bits SHALL be reused every cycle.

Verification
REQ-033 WIDTH=64, unsigned, a=100, b=7 -> after 66 cycles out_valid=1, quo=14, rem=2, dbz=0, ovf=0.
REQ-034 WIDTH=8, signed, a=-7 (0xF9), b=2 -> quo=0xFD (-3), rem=0xFF (-1); a=7, b=-2 -> quo=0xFD, rem=0x01.
REQ-035 WIDTH=8, b=0, a=0x35 -> out_valid on the cycle after accept, quo=0xFF, rem=0x35, dbz=1.
REQ-036 WIDTH=8, signed, a=0x80, b=0xFF -> quo=0x80, rem=0x00, ovf=1; the same operands unsigned -> quo=0x00, rem=0x80, ovf=0.
REQ-037 Hold out_ready=0 for 5 cycles in DONE, then 1 -> outputs stable throughout, in_ready=0 until the cycle after the handshake.
REQ-038 Assert rst for 1 cycle midway through DIV -> next cycle IDLE, all outputs 0; a following operation a=9, b=3 -> quo=3, rem=0.
